// File: rtl/serial_pair_serializer_if.sv
// Word-pair input handshake and serial bit output bundle for serial_pair_serializer.
interface serial_pair_serializer_if #(
    parameter int unsigned W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         abort;
    logic         ser_valid;
    logic         ser_a;
    logic         ser_b;
    logic         ser_first;
    logic         ser_last;

    // Upstream feeder / consumer side.
    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output abort,
        input  in_ready,
        input  ser_valid,
        input  ser_a,
        input  ser_b,
        input  ser_first,
        input  ser_last
    );

    // Serializer side.
    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  abort,
        output in_ready,
        output ser_valid,
        output ser_a,
        output ser_b,
        output ser_first,
        output ser_last
    );
endinterface

// File: rtl/serial_pair_serializer.sv
// Serializes a pair of W-bit words one bit per clock, MSB- or LSB-first, with framing strobes.
module serial_pair_serializer #(
    parameter int unsigned W         = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    serial_pair_serializer_if.slave  bus
);

    localparam int unsigned   CW     = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CntMax = CW'(W - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  sh_a_q, sh_a_d;
    logic [W-1:0]  sh_b_q, sh_b_d;
    logic          ser_valid_q, ser_valid_d;
    logic          ser_a_q, ser_a_d;
    logic          ser_b_q, ser_b_d;
    logic          ser_first_q, ser_first_d;
    logic          ser_last_q, ser_last_d;
    logic          at_last;
    logic          accept;

    // The shift register always keeps the bit currently on the wire in its head position.
    function automatic logic [W-1:0] advance(input logic [W-1:0] v);
        return MSB_FIRST ? (v << 1) : (v >> 1);
    endfunction

    function automatic logic head(input logic [W-1:0] v);
        return MSB_FIRST ? v[W-1] : v[0];
    endfunction

    assign at_last      = (cnt_q == CntMax);
    // Ready on the last bit lets a new pair follow with no bubble; abort blocks that load.
    assign bus.in_ready = (state_q == StIdle) ||
                          ((state_q == StShift) && at_last && !bus.abort);
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.ser_valid = ser_valid_q;
    assign bus.ser_a     = ser_a_q;
    assign bus.ser_b     = ser_b_q;
    assign bus.ser_first = ser_first_q;
    assign bus.ser_last  = ser_last_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (at_last) begin
                    state_d = accept ? StShift : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        cnt_d       = cnt_q;
        sh_a_d      = sh_a_q;
        sh_b_d      = sh_b_q;
        ser_valid_d = 1'b0;
        ser_a_d     = 1'b0;
        ser_b_d     = 1'b0;
        ser_first_d = 1'b0;
        ser_last_d  = 1'b0;
        if (accept) begin
            cnt_d       = '0;
            sh_a_d      = bus.in_a;
            sh_b_d      = bus.in_b;
            ser_valid_d = 1'b1;
            ser_a_d     = head(bus.in_a);
            ser_b_d     = head(bus.in_b);
            ser_first_d = 1'b1;
            ser_last_d  = (CntMax == '0);
        end else if ((state_q == StShift) && !bus.abort && !at_last) begin
            cnt_d       = cnt_q + CW'(1);
            sh_a_d      = advance(sh_a_q);
            sh_b_d      = advance(sh_b_q);
            ser_valid_d = 1'b1;
            ser_a_d     = head(advance(sh_a_q));
            ser_b_d     = head(advance(sh_b_q));
            ser_last_d  = ((cnt_q + CW'(1)) == CntMax);
        end else if (state_q == StShift) begin
            // Word finished or aborted: outputs fall to zero via the defaults.
            cnt_d = '0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            ser_valid_q <= 1'b0;
            ser_a_q     <= 1'b0;
            ser_b_q     <= 1'b0;
            ser_first_q <= 1'b0;
            ser_last_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            sh_a_q      <= sh_a_d;
            sh_b_q      <= sh_b_d;
            ser_valid_q <= ser_valid_d;
            ser_a_q     <= ser_a_d;
            ser_b_q     <= ser_b_d;
            ser_first_q <= ser_first_d;
            ser_last_q  <= ser_last_d;
        end
    end

endmodule

// File: tb/tb_serial_pair_serializer.sv
// Scoreboard bench: MSB-first and LSB-first W=8 instances share stimulus; a W=1 instance is separate.
module tb_serial_pair_serializer;

    typedef struct packed {
        logic a;
        logic b;
        logic first;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q_m[$];
    exp_t q_l[$];
    exp_t q_1[$];
    int   run_m      = 0;
    int   last_run_m = 0;

    always #5 clk = ~clk;

    serial_pair_serializer_if #(.W(8)) if_m ();
    serial_pair_serializer_if #(.W(8)) if_l ();
    serial_pair_serializer_if #(.W(1)) if_1 ();

    serial_pair_serializer #(.W(8), .MSB_FIRST(1'b1)) u_m (.clk(clk), .rst(rst), .bus(if_m));
    serial_pair_serializer #(.W(8), .MSB_FIRST(1'b0)) u_l (.clk(clk), .rst(rst), .bus(if_l));
    serial_pair_serializer #(.W(1), .MSB_FIRST(1'b1)) u_1 (.clk(clk), .rst(rst), .bus(if_1));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ma/mb: MSB-first bit sequence, la/lb: LSB-first sequence, both read left to right.
    task automatic push8(input logic [7:0] ma, input logic [7:0] mb,
                         input logic [7:0] la, input logic [7:0] lb, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.first = (i == 0);
            e.last  = (i == 7);
            e.a = ma[7-i];
            e.b = mb[7-i];
            q_m.push_back(e);
            e.a = la[7-i];
            e.b = lb[7-i];
            q_l.push_back(e);
        end
    endtask

    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b,
                          input logic ab);
        if_m.in_valid = v;
        if_m.in_a     = a;
        if_m.in_b     = b;
        if_m.abort    = ab;
        if_l.in_valid = v;
        if_l.in_a     = a;
        if_l.in_b     = b;
        if_l.abort    = ab;
    endtask

    // Monitors: pop one expected bit per ser_valid cycle; outputs must be zero otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (if_m.ser_valid) begin
            run_m++;
            if (q_m.size() == 0) begin
                chk("msb unexpected bit", 1, 0);
            end else begin
                e = q_m.pop_front();
                chk("msb bit {a,b,first,last}",
                    {if_m.ser_a, if_m.ser_b, if_m.ser_first, if_m.ser_last}, e);
            end
        end else begin
            if (run_m != 0) last_run_m = run_m;
            run_m = 0;
            chk("msb idle outputs", {if_m.ser_a, if_m.ser_b, if_m.ser_first, if_m.ser_last}, 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (if_l.ser_valid) begin
            if (q_l.size() == 0) begin
                chk("lsb unexpected bit", 1, 0);
            end else begin
                e = q_l.pop_front();
                chk("lsb bit {a,b,first,last}",
                    {if_l.ser_a, if_l.ser_b, if_l.ser_first, if_l.ser_last}, e);
            end
        end else begin
            chk("lsb idle outputs", {if_l.ser_a, if_l.ser_b, if_l.ser_first, if_l.ser_last}, 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (if_1.ser_valid) begin
            if (q_1.size() == 0) begin
                chk("w1 unexpected bit", 1, 0);
            end else begin
                e = q_1.pop_front();
                chk("w1 bit {a,b,first,last}",
                    {if_1.ser_a, if_1.ser_b, if_1.ser_first, if_1.ser_last}, e);
            end
        end else begin
            chk("w1 idle outputs", {if_1.ser_a, if_1.ser_b, if_1.ser_first, if_1.ser_last}, 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   waited;
        exp_t e;
        drive8(1'b0, 8'h00, 8'h00, 1'b0);
        if_1.in_valid = 1'b0;
        if_1.in_a     = 1'b0;
        if_1.in_b     = 1'b0;
        if_1.abort    = 1'b0;

        // Reset state.
        #1 rst = 1'b0;
        #2;
        chk("reset in_ready msb", if_m.in_ready, 1);
        chk("reset in_ready w1", if_1.in_ready, 1);
        chk("reset ser_valid msb", if_m.ser_valid, 0);
        chk("reset ser_valid lsb", if_l.ser_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // 1/2: single word 0x64/0x62, both bit orders; inputs change after accept.
        @(posedge clk); #1;
        drive8(1'b1, 8'h64, 8'h62, 1'b0);
        chk("idle in_ready", if_m.in_ready, 1);
        push8(8'b01100100, 8'b01100010, 8'b00100110, 8'b01000110, 8);
        @(posedge clk); #1;
        drive8(1'b0, 8'hFF, 8'h00, 1'b0);
        repeat (10) @(posedge clk);

        // 3: back-to-back pairs with in_valid held.
        #1;
        drive8(1'b1, 8'hC1, 8'h1E, 1'b0);
        push8(8'b11000001, 8'b00011110, 8'b10000011, 8'b01111000, 8);
        @(posedge clk); #1;
        drive8(1'b1, 8'h3A, 8'h95, 1'b0);
        push8(8'b00111010, 8'b10010101, 8'b01011100, 8'b10101001, 8);
        waited = 1;
        while (!if_m.in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("b2b in_ready on bit cycle", waited, 8);
        chk("b2b in_ready lsb", if_l.in_ready, 1);
        @(posedge clk); #1;
        drive8(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (10) @(posedge clk);
        chk("b2b consecutive valid cycles", last_run_m, 16);

        // 4: abort on the 4th bit; abort stays high through an accept in IDLE.
        #1;
        drive8(1'b1, 8'hF0, 8'h0F, 1'b0);
        push8(8'b11110000, 8'b00001111, 8'b00001111, 8'b11110000, 4);
        @(posedge clk); #1;
        drive8(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) @(posedge clk); #1;
        drive8(1'b1, 8'h64, 8'h62, 1'b1);
        chk("abort cycle in_ready msb", if_m.in_ready, 0);
        chk("abort cycle in_ready lsb", if_l.in_ready, 0);
        @(posedge clk); #1;
        chk("after abort ser_valid msb", if_m.ser_valid, 0);
        chk("after abort ser_valid lsb", if_l.ser_valid, 0);
        chk("after abort in_ready msb", if_m.in_ready, 1);
        push8(8'b01100100, 8'b01100010, 8'b00100110, 8'b01000110, 8);
        @(posedge clk); #1;
        drive8(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (10) @(posedge clk);

        // 5: asynchronous reset in the 3rd bit cycle.
        #1;
        drive8(1'b1, 8'hFF, 8'hFF, 1'b0);
        push8(8'hFF, 8'hFF, 8'hFF, 8'hFF, 2);
        @(posedge clk); #1;
        drive8(1'b0, 8'h00, 8'h00, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("mid-word reset ser msb", {if_m.ser_valid, if_m.ser_a, if_m.ser_b,
                                       if_m.ser_first, if_m.ser_last}, 0);
        chk("mid-word reset ser lsb", {if_l.ser_valid, if_l.ser_a, if_l.ser_b,
                                       if_l.ser_first, if_l.ser_last}, 0);
        chk("mid-word reset in_ready", if_m.in_ready, 1);
        #3 rst = 1'b1;
        #1;
        chk("post-reset in_ready msb", if_m.in_ready, 1);
        chk("post-reset in_ready lsb", if_l.in_ready, 1);
        repeat (3) @(posedge clk);

        // 6: W=1, two words back to back.
        #1;
        if_1.in_valid = 1'b1;
        if_1.in_a     = 1'b1;
        if_1.in_b     = 1'b0;
        e = '{a: 1'b1, b: 1'b0, first: 1'b1, last: 1'b1};
        q_1.push_back(e);
        @(posedge clk); #1;
        chk("w1 in_ready on only bit", if_1.in_ready, 1);
        if_1.in_a = 1'b0;
        if_1.in_b = 1'b1;
        e = '{a: 1'b0, b: 1'b1, first: 1'b1, last: 1'b1};
        q_1.push_back(e);
        @(posedge clk); #1;
        if_1.in_valid = 1'b0;
        repeat (4) @(posedge clk);

        #1;
        chk("msb queue drained", q_m.size(), 0);
        chk("lsb queue drained", q_l.size(), 0);
        chk("w1 queue drained", q_1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
